sprite_line_scheduler: RTL and testbench
========================================

SPRITE_LINE_SCHEDULER -- requirements
Module: sprite_line_scheduler

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 16, meaning number of sprite table entries scanned per line (power of two, 2..64).
REQ-002 SHALL have parameter NUM_SLOTS, default 4, meaning maximum sprites rendered on one line (1..8).
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port line_start, input, 1, one-cycle pulse from the display timing at start of horizontal blank.
REQ-006 SHALL have port next_row, input, 11, world y of the line to be prepared (offset_y + display_row + 1, mod 2048).
REQ-007 SHALL have port tab_rd, output, 1, sprite table read strobe.
REQ-008 SHALL have port tab_addr, output, log2(NUM_ENTRIES), sprite table entry index.
REQ-009 SHALL have port tab_data, input, 30, entry read; valid exactly one cycle after tab_rd; format [10:0] xpos, [21:11] ypos, [27:22] char, [29:28] palette.
REQ-010 SHALL have port pix_x, input, 11, world x of the pixel being fetched (offset_x + display_col, mod 2048).
REQ-011 SHALL have ports sprite_enable (1), sel_char (6), sel_pal (2), sel_rel_x (4), sel_rel_y (4), outputs, the selected sprite pixel lookup.
REQ-012 SHALL have ports busy (1), done (1), overflow (1), outputs, scan status.

Function
REQ-013 SHALL be in one of IDLE, SCAN, COMMIT; reset enters IDLE.
REQ-014 In IDLE, a sampled line_start SHALL latch next_row into row_r, clear the working slot set, and enter SCAN; busy=1 from the next cycle.
REQ-015 In SCAN, tab_rd SHALL be 1 with tab_addr = 0,1,..,NUM_ENTRIES-1 on consecutive cycles, no gaps.
REQ-016 Each returned entry SHALL be checked the cycle its data is valid: diff = (row_r - ypos) mod 2048 (11-bit unsigned); hit when diff < 16 and char != 0; rel_y = diff[3:0].
REQ-017 Vertical wrap SHALL be native: ypos=2040, row_r=3 gives diff=11, hit.
REQ-018 Hits SHALL fill working slots in ascending table index order (slot 0 = lowest index = highest priority), storing xpos, char, palette, rel_y.
REQ-019 A hit when NUM_SLOTS slots are already filled SHALL set the working overflow flag and SHALL NOT alter any slot.
REQ-020 Scan duration SHALL be fixed regardless of hits: after the last entry check, enter COMMIT.
REQ-021 COMMIT SHALL copy working slots and overflow to the active set atomically in one cycle, then return to IDLE; done=1 for exactly that one cycle after the copy, busy=0 with it.
REQ-022 Latency: with line_start sampled at edge 0, tab_rd is high after edges 1..NUM_ENTRIES, and done plus new active slots appear after edge NUM_ENTRIES+3 (19 at defaults).
REQ-023 line_start while busy SHALL be ignored; active set unchanged until COMMIT.
REQ-024 Pixel stage, registered one cycle: candidate slot s when active valid and dx = (pix_x - xpos_s) mod 2048 < 16; lowest-index candidate selected.
REQ-025 With a candidate: sprite_enable=1, sel_char, sel_pal, sel_rel_y from slot, sel_rel_x = dx[3:0]. With none: sprite_enable=0 and sel_* = 0.
REQ-026 Pixel stage SHALL read only the active set and run every cycle, including during SCAN.

Reset
REQ-027 reset low SHALL immediately force IDLE, tab_rd=0, tab_addr=0, busy=0, done=0, overflow=0, all working and active slots invalid, sprite_enable=0, sel_*=0.
REQ-028 Reset asserted mid-SCAN SHALL abort the scan with no partial commit; first line_start after release starts a full scan.

Verification
REQ-029 Table: entry 3 ypos=100 char=5 pal=2 xpos=200; line_start with next_row=107 -> done after edge 19, slot 0 valid with rel_y=7; pix_x=205 -> next cycle sprite_enable=1, sel_char=5, sel_pal=2, sel_rel_x=5, sel_rel_y=7.
REQ-030 Entries 1,2,4,7,9 all hit row 50 -> slots hold entries 1,2,4,7; overflow=1; entry 9 absent.
REQ-031 Entries 0 and 5 overlap at pix_x=300 (xpos 290 and 295) -> sel_char from entry 0; entry 0 char=0 -> entry 5 selected.
REQ-032 ypos=2040, next_row=3 -> hit, rel_y=11; xpos=2045, pix_x=4 -> sprite_enable=1, sel_rel_x=7.
REQ-033 line_start pulsed again at edge 5 of a scan -> ignored, done once at edge 19; reset pulsed at edge 10 -> all outputs zero, no done, next scan complete and correct.

Source files
------------

// File: rtl/sprite_line_scheduler.sv
// Per-line sprite evaluation: scans the sprite table during horizontal blank,
// commits up to NUM_SLOTS hits atomically, and resolves the sprite pixel each cycle.
`timescale 1ns/1ps
module sprite_line_scheduler #(
  parameter int NUM_ENTRIES = 16,
  parameter int NUM_SLOTS   = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           line_start,
  input  logic [10:0]                    next_row,
  output logic                           tab_rd,
  output logic [$clog2(NUM_ENTRIES)-1:0] tab_addr,
  input  logic [29:0]                    tab_data,
  input  logic [10:0]                    pix_x,
  output logic                           sprite_enable,
  output logic [5:0]                     sel_char,
  output logic [1:0]                     sel_pal,
  output logic [3:0]                     sel_rel_x,
  output logic [3:0]                     sel_rel_y,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow
);

  localparam int AW = $clog2(NUM_ENTRIES);
  localparam int SW = $clog2(NUM_SLOTS + 1);
  localparam logic [AW:0]   ENTRY_COUNT = (AW+1)'(NUM_ENTRIES);
  localparam logic [AW-1:0] LAST_ADDR   = AW'(NUM_ENTRIES - 1);
  localparam logic [SW-1:0] SLOT_COUNT  = SW'(NUM_SLOTS);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t          state_reg;
  logic [10:0]     row_reg;
  logic [AW:0]     issue_cnt_reg;
  logic            tab_rd_reg;
  logic [AW-1:0]   tab_addr_reg;
  logic            chk_valid_reg;
  logic            chk_last_reg;
  logic            busy_reg;
  logic            done_reg;
  logic [SW-1:0]   w_count_reg;
  logic            w_ovf_reg;
  logic            a_ovf_reg;

  logic            w_valid_reg [NUM_SLOTS];
  logic [10:0]     w_xpos_reg  [NUM_SLOTS];
  logic [5:0]      w_char_reg  [NUM_SLOTS];
  logic [1:0]      w_pal_reg   [NUM_SLOTS];
  logic [3:0]      w_rely_reg  [NUM_SLOTS];

  logic            a_valid_reg [NUM_SLOTS];
  logic [10:0]     a_xpos_reg  [NUM_SLOTS];
  logic [5:0]      a_char_reg  [NUM_SLOTS];
  logic [1:0]      a_pal_reg   [NUM_SLOTS];
  logic [3:0]      a_rely_reg  [NUM_SLOTS];

  // Entry check: the 11-bit subtraction makes vertical wrap-around free.
  logic [10:0] ent_xpos;
  logic [10:0] ent_ypos;
  logic [5:0]  ent_char;
  logic [1:0]  ent_pal;
  logic [10:0] ent_diff;
  logic        ent_hit;

  assign ent_xpos = tab_data[10:0];
  assign ent_ypos = tab_data[21:11];
  assign ent_char = tab_data[27:22];
  assign ent_pal  = tab_data[29:28];
  assign ent_diff = row_reg - ent_ypos;
  assign ent_hit  = chk_valid_reg && (ent_diff[10:4] == 7'd0) && (ent_char != 6'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      row_reg       <= '0;
      issue_cnt_reg <= '0;
      tab_rd_reg    <= 1'b0;
      tab_addr_reg  <= '0;
      chk_valid_reg <= 1'b0;
      chk_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      w_count_reg   <= '0;
      w_ovf_reg     <= 1'b0;
      a_ovf_reg     <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        w_valid_reg[i] <= 1'b0;
        w_xpos_reg[i]  <= '0;
        w_char_reg[i]  <= '0;
        w_pal_reg[i]   <= '0;
        w_rely_reg[i]  <= '0;
        a_valid_reg[i] <= 1'b0;
        a_xpos_reg[i]  <= '0;
        a_char_reg[i]  <= '0;
        a_pal_reg[i]   <= '0;
        a_rely_reg[i]  <= '0;
      end
    end else begin
      done_reg      <= 1'b0;
      // Table data arrives one cycle after the strobe; track which cycles carry it.
      chk_valid_reg <= tab_rd_reg;
      chk_last_reg  <= tab_rd_reg && (tab_addr_reg == LAST_ADDR);
      case (state_reg)
        IDLE: begin
          if (line_start) begin
            row_reg       <= next_row;
            issue_cnt_reg <= '0;
            w_count_reg   <= '0;
            w_ovf_reg     <= 1'b0;
            busy_reg      <= 1'b1;
            state_reg     <= SCAN;
            for (int i = 0; i < NUM_SLOTS; i++) begin
              w_valid_reg[i] <= 1'b0;
            end
          end
        end
        SCAN: begin
          if (issue_cnt_reg < ENTRY_COUNT) begin
            tab_rd_reg    <= 1'b1;
            tab_addr_reg  <= issue_cnt_reg[AW-1:0];
            issue_cnt_reg <= issue_cnt_reg + 1'b1;
          end else begin
            tab_rd_reg    <= 1'b0;
            tab_addr_reg  <= '0;
          end
          if (ent_hit) begin
            if (w_count_reg == SLOT_COUNT) begin
              w_ovf_reg <= 1'b1;
            end else begin
              for (int i = 0; i < NUM_SLOTS; i++) begin
                if (w_count_reg == SW'(i)) begin
                  w_valid_reg[i] <= 1'b1;
                  w_xpos_reg[i]  <= ent_xpos;
                  w_char_reg[i]  <= ent_char;
                  w_pal_reg[i]   <= ent_pal;
                  w_rely_reg[i]  <= ent_diff[3:0];
                end
              end
              w_count_reg <= w_count_reg + 1'b1;
            end
          end
          if (chk_last_reg) begin
            state_reg <= COMMIT;
          end
        end
        COMMIT: begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            a_valid_reg[i] <= w_valid_reg[i];
            a_xpos_reg[i]  <= w_xpos_reg[i];
            a_char_reg[i]  <= w_char_reg[i];
            a_pal_reg[i]   <= w_pal_reg[i];
            a_rely_reg[i]  <= w_rely_reg[i];
          end
          a_ovf_reg <= w_ovf_reg;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Pixel stage: per-slot horizontal window test against the active set only.
  logic [NUM_SLOTS-1:0]      cand;
  logic [NUM_SLOTS-1:0][3:0] cand_rel_x;

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_cand
      logic [10:0] dx;
      assign dx             = pix_x - a_xpos_reg[gi];
      assign cand[gi]       = a_valid_reg[gi] && (dx[10:4] == 7'd0);
      assign cand_rel_x[gi] = dx[3:0];
    end
  endgenerate

  logic       pick_en_next;
  logic [5:0] pick_char_next;
  logic [1:0] pick_pal_next;
  logic [3:0] pick_rx_next;
  logic [3:0] pick_ry_next;

  always_comb begin
    pick_en_next   = 1'b0;
    pick_char_next = '0;
    pick_pal_next  = '0;
    pick_rx_next   = '0;
    pick_ry_next   = '0;
    // Walk downwards so the lowest-index candidate wins.
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        pick_en_next   = 1'b1;
        pick_char_next = a_char_reg[i];
        pick_pal_next  = a_pal_reg[i];
        pick_rx_next   = cand_rel_x[i];
        pick_ry_next   = a_rely_reg[i];
      end
    end
  end

  logic       en_reg;
  logic [5:0] char_reg;
  logic [1:0] pal_reg;
  logic [3:0] rx_reg;
  logic [3:0] ry_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      en_reg   <= 1'b0;
      char_reg <= '0;
      pal_reg  <= '0;
      rx_reg   <= '0;
      ry_reg   <= '0;
    end else begin
      en_reg   <= pick_en_next;
      char_reg <= pick_char_next;
      pal_reg  <= pick_pal_next;
      rx_reg   <= pick_rx_next;
      ry_reg   <= pick_ry_next;
    end
  end

  assign tab_rd        = tab_rd_reg;
  assign tab_addr      = tab_addr_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign overflow      = a_ovf_reg;
  assign sprite_enable = en_reg;
  assign sel_char      = char_reg;
  assign sel_pal       = pal_reg;
  assign sel_rel_x     = rx_reg;
  assign sel_rel_y     = ry_reg;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Scoreboard bench for sprite_line_scheduler: a line-level reference model predicts
// every output cycle; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_sprite_line_scheduler;
  localparam int N  = 16;
  localparam int S  = 4;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          line_start = 1'b0;
  logic [10:0]   next_row = '0;
  logic          tab_rd;
  logic [AW-1:0] tab_addr;
  logic [29:0]   tab_data = '0;
  logic [10:0]   pix_x = '0;
  logic          sprite_enable;
  logic [5:0]    sel_char;
  logic [1:0]    sel_pal;
  logic [3:0]    sel_rel_x;
  logic [3:0]    sel_rel_y;
  logic          busy;
  logic          done;
  logic          overflow;

  always #5 clock = ~clock;

  sprite_line_scheduler #(.NUM_ENTRIES(N), .NUM_SLOTS(S)) dut (
    .clock(clock), .reset(reset), .line_start(line_start), .next_row(next_row),
    .tab_rd(tab_rd), .tab_addr(tab_addr), .tab_data(tab_data), .pix_x(pix_x),
    .sprite_enable(sprite_enable), .sel_char(sel_char), .sel_pal(sel_pal),
    .sel_rel_x(sel_rel_x), .sel_rel_y(sel_rel_y),
    .busy(busy), .done(done), .overflow(overflow)
  );

  typedef struct packed {
    logic          rd;
    logic [AW-1:0] addr;
    logic          busy;
    logic          done;
    logic          ovf;
    logic          en;
    logic [5:0]    ch;
    logic [1:0]    pal;
    logic [3:0]    rx;
    logic [3:0]    ry;
  } obs_t;

  obs_t exp_q[$];
  int   commit_edge_q[$];
  logic commit_ovf_q[$];

  int total  = 0;
  int passed = 0;
  int edge_n = 0;

  // Sprite table contents and the reference model's view of the line buffers.
  logic [29:0] mem [N];
  logic        m_valid [S];
  logic [10:0] m_x [S];
  logic [5:0]  m_ch [S];
  logic [1:0]  m_pal [S];
  logic [3:0]  m_ry [S];
  logic        m_ovf = 1'b0;
  logic        p_valid [S];
  logic [10:0] p_x [S];
  logic [5:0]  p_ch [S];
  logic [1:0]  p_pal [S];
  logic [3:0]  p_ry [S];
  logic        p_ovf = 1'b0;
  logic        p_active = 1'b0;
  int          p_start = 0;
  logic          prev_rd = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, expv, edge_n);
  endtask

  function automatic logic [29:0] entry(input int x, input int y, input int c, input int p);
    return {2'(p), 6'(c), 11'(y), 11'(x)};
  endfunction

  task automatic clear_model();
    for (int s = 0; s < S; s++) begin
      m_valid[s] = 1'b0; m_x[s] = '0; m_ch[s] = '0; m_pal[s] = '0; m_ry[s] = '0;
    end
    m_ovf = 1'b0;
    p_active = 1'b0;
    commit_edge_q.delete();
    commit_ovf_q.delete();
  endtask

  // Which sprites land on a row: first S visible entries in table order.
  task automatic compute_line(input logic [10:0] row);
    int cnt;
    cnt = 0;
    p_ovf = 1'b0;
    for (int s = 0; s < S; s++) p_valid[s] = 1'b0;
    for (int e = 0; e < N; e++) begin
      int d;
      logic [29:0] w;
      w = mem[e];
      d = (int'(row) - int'(w[21:11]) + 2048) % 2048;
      if (d < 16 && w[27:22] != 6'd0) begin
        if (cnt < S) begin
          p_valid[cnt] = 1'b1; p_x[cnt] = w[10:0]; p_ch[cnt] = w[27:22];
          p_pal[cnt] = w[29:28]; p_ry[cnt] = 4'(d);
          cnt++;
        end else begin
          p_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    obs_t e;
    logic accept;
    logic commit_now;
    logic found;
    @(posedge clock);
    edge_n++;
    e = '0;
    if (reset) begin
      found = 1'b0;
      for (int s = 0; s < S; s++) begin
        if (!found && m_valid[s]) begin
          int dx;
          dx = (int'(pix_x) - int'(m_x[s]) + 2048) % 2048;
          if (dx < 16) begin
            found = 1'b1; e.en = 1'b1; e.ch = m_ch[s]; e.pal = m_pal[s];
            e.rx = 4'(dx); e.ry = m_ry[s];
          end
        end
      end
      accept = line_start && !p_active;
      commit_now = p_active && (edge_n == p_start + N + 3);
      if (commit_now) begin
        for (int s = 0; s < S; s++) begin
          m_valid[s] = p_valid[s]; m_x[s] = p_x[s]; m_ch[s] = p_ch[s];
          m_pal[s] = p_pal[s]; m_ry[s] = p_ry[s];
        end
        m_ovf = p_ovf;
        p_active = 1'b0;
      end
      if (accept) begin
        compute_line(next_row);
        p_active = 1'b1;
        p_start = edge_n;
        commit_edge_q.push_back(edge_n + N + 3);
        commit_ovf_q.push_back(p_ovf);
      end
      e.done = commit_now;
      e.ovf  = m_ovf;
      if (p_active) begin
        e.busy = 1'b1;
        if (edge_n >= p_start + 1 && edge_n <= p_start + N) begin
          e.rd = 1'b1;
          e.addr = AW'(edge_n - p_start - 1);
        end
      end
    end
    exp_q.push_back(e);
    #1;
    tab_data  = prev_rd ? mem[prev_addr] : 30'($urandom);
    prev_rd   = tab_rd;
    prev_addr = tab_addr;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic start_line(input int row);
    next_row = 11'(row);
    line_start = 1'b1;
    step();
    line_start = 1'b0;
  endtask

  task automatic line_and_wait(input string name, input int row);
    start_line(row);
    run(N + 3);
    check({name, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic check_pix(input string name, input logic en, input int ch, input int pal,
                           input int rx, input int ry);
    logic [16:0] expv;
    expv = {en, 6'(ch), 2'(pal), 4'(rx), 4'(ry)};
    check(name, 64'({sprite_enable, sel_char, sel_pal, sel_rel_x, sel_rel_y}), 64'(expv));
  endtask

  task automatic check_all_zero(input string name);
    check(name, 64'({tab_rd, tab_addr, busy, done, overflow, sprite_enable,
                     sel_char, sel_pal, sel_rel_x, sel_rel_y}), 64'd0);
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    clear_model();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < N; i++) mem[i] = '0;
  endtask

  // Monitor: one expected record per clock, plus a commit record per done pulse.
  initial begin
    obs_t ex;
    obs_t act;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        ex = exp_q.pop_front();
        act = '{rd: tab_rd, addr: tab_addr, busy: busy, done: done, ovf: overflow,
                en: sprite_enable, ch: sel_char, pal: sel_pal, rx: sel_rel_x, ry: sel_rel_y};
        if (!reset) ex = '0;
        check("cycle", 64'(act), 64'(ex));
        if (done && reset) begin
          if (commit_edge_q.size() == 0) begin
            check("unexpected_done", 64'(done), 64'd0);
          end else begin
            check("done_edge", 64'(edge_n), 64'(commit_edge_q.pop_front()));
            check("done_overflow", 64'(overflow), 64'(commit_ovf_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    clear_mem();
    clear_model();
    run(2);
    check_all_zero("reset_state");
    reset = 1'b1;
    run(2);

    // Single sprite, latency and pixel lookup.
    mem[3] = entry(200, 100, 5, 2);
    pix_x = 11'd205;
    line_and_wait("basic", 107);
    check_pix("basic_old_active", 1'b0, 0, 0, 0, 0);
    step();
    check_pix("basic_pix", 1'b1, 5, 2, 5, 7);
    check("basic_done_once", 64'(done), 64'd0);
    pix_x = 11'd199; step();
    check_pix("basic_left_edge", 1'b0, 0, 0, 0, 0);
    pix_x = 11'd215; step();
    check_pix("basic_right_edge", 1'b1, 5, 2, 15, 7);
    pix_x = 11'd216; step();
    check_pix("basic_past_right", 1'b0, 0, 0, 0, 0);

    // Overflow: five hits, slot limit four; plus a diff=16 miss and a char=0 miss.
    clear_mem();
    mem[1] = entry(100, 40, 11, 1);
    mem[2] = entry(300, 45, 12, 1);
    mem[4] = entry(500, 50, 13, 1);
    mem[7] = entry(700, 35, 14, 1);
    mem[9] = entry(900, 42, 15, 1);
    mem[5] = entry(1100, 34, 20, 1);
    mem[6] = entry(1300, 50, 0, 1);
    line_and_wait("ovf", 50);
    step();
    check("ovf_flag", 64'(overflow), 64'd1);
    pix_x = 11'd705; step();
    check_pix("ovf_slot3", 1'b1, 14, 1, 5, 15);
    pix_x = 11'd905; step();
    check_pix("ovf_dropped", 1'b0, 0, 0, 0, 0);
    pix_x = 11'd1105; step();
    check_pix("ovf_diff16", 1'b0, 0, 0, 0, 0);
    pix_x = 11'd1305; step();
    check_pix("ovf_char0", 1'b0, 0, 0, 0, 0);

    // Horizontal priority between overlapping sprites.
    clear_mem();
    mem[0] = entry(290, 60, 9, 1);
    mem[5] = entry(295, 60, 12, 3);
    pix_x = 11'd300;
    line_and_wait("prio", 60);
    step();
    check_pix("prio_entry0", 1'b1, 9, 1, 10, 0);
    check("prio_no_ovf", 64'(overflow), 64'd0);
    mem[0] = entry(290, 60, 0, 1);
    line_and_wait("prio2", 60);
    step();
    check_pix("prio_entry5", 1'b1, 12, 3, 5, 0);

    // Wrap in both axes.
    clear_mem();
    mem[10] = entry(2045, 2040, 33, 2);
    pix_x = 11'd4;
    line_and_wait("wrap", 3);
    step();
    check_pix("wrap_pix", 1'b1, 33, 2, 7, 11);

    // line_start while busy is ignored.
    clear_mem();
    mem[2] = entry(50, 500, 7, 1);
    pix_x = 11'd52;
    start_line(505);
    run(4);
    next_row = 11'd600; line_start = 1'b1; step(); line_start = 1'b0;
    run(N + 3 - 5);
    check("busy_ignore_done", 64'(done), 64'd1);
    step();
    check_pix("busy_ignore_row", 1'b1, 7, 1, 2, 5);
    run(N + 4);

    // Reset in the middle of a scan.
    start_line(510);
    run(10);
    assert_reset();
    #1;
    check_all_zero("reset_mid_scan");
    run(2);
    reset = 1'b1;
    run(N + 5);
    check("reset_no_done", 64'(done), 64'd0);
    line_and_wait("after_reset", 510);
    step();
    check_pix("after_reset_pix", 1'b1, 7, 1, 2, 10);

    // Randomised lines against the model.
    for (int l = 0; l < 40; l++) begin
      if (!p_active) begin
        logic [10:0] row;
        row = 11'($urandom);
        for (int i = 0; i < N; i++) begin
          mem[i] = entry($urandom_range(0, 2047),
                         (int'(row) - int'($urandom_range(0, 24)) + 2048) % 2048,
                         ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 63),
                         $urandom_range(0, 3));
        end
        start_line(int'(row));
      end
      for (int c = 0; c < int'($urandom_range(5, 30)); c++) begin
        int k;
        k = $urandom_range(0, S - 1);
        pix_x = m_valid[k] ? 11'(int'(m_x[k]) + int'($urandom_range(0, 17))) : 11'($urandom);
        line_start = ($urandom_range(0, 5) == 0);
        next_row = 11'($urandom);
        step();
        line_start = 1'b0;
      end
      if ($urandom_range(0, 24) == 0) begin
        assert_reset();
        step();
        reset = 1'b1;
      end
    end
    run(N + 6);
    @(negedge clock);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("commits_seen", 64'(commit_edge_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
